feed_writer: RTL and testbench

FEED_WRITER -- requirements
Module: feed_writer

---
 rtl/feed_writer_if.sv | 30 +++
 rtl/feed_writer.sv | 149 ++++++++++++++
 tb/tb_feed_writer.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/feed_writer_if.sv
`default_nettype none
// ============================================================================
//  Module      : feed_writer_if
//  Description : Avalon-MM write-only master bus used by feed_writer to
//                stream sample words into an SDRAM ring buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface feed_writer_if #(
  parameter int ADDR_W = 24
) ();
  logic [ADDR_W-1:0] avm_address;
  logic              avm_write;
  logic [15:0]       avm_writedata;
  logic              avm_waitrequest;

  modport master (
    output avm_address,
    output avm_write,
    output avm_writedata,
    input  avm_waitrequest
  );

  modport slave (
    input  avm_address,
    input  avm_write,
    input  avm_writedata,
    output avm_waitrequest
  );
endinterface
`default_nettype wire

// File: rtl/feed_writer.sv
`default_nettype none
// ============================================================================
//  Module      : feed_writer
//  Description : Captures a 16-bit sample stream into a small FIFO and writes
//                it word by word into an SDRAM ring buffer over Avalon-MM.
//                Control FSM: IDLE -> RUN (capture) -> DRAIN (flush) -> IDLE.
//  Revision    : 1.0 - initial release
// ============================================================================
module feed_writer #(
  parameter int              ADDR_W    = 24,
  parameter longint unsigned BASE_ADDR = 0,
  parameter longint unsigned RING_LEN  = 1024,
  parameter int              DEPTH     = 8
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic        start,
  input  wire logic        stop,
  input  wire logic        sample_valid,
  input  wire logic [15:0] sample_data,
  feed_writer_if.master    avm,
  output logic             busy,
  output logic             overflow,
  output logic             wrapped,
  output logic [31:0]      words_written
);

  localparam int                c_ptr_w = $clog2(DEPTH);
  localparam int                c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);
  localparam logic [ADDR_W-1:0] c_base  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] c_last  = ADDR_W'(BASE_ADDR + RING_LEN - 64'd1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [15:0]         r_mem [DEPTH];
  logic [c_ptr_w-1:0]  r_rd_ptr;
  logic [c_ptr_w-1:0]  r_wr_ptr;
  logic [c_cnt_w-1:0]  r_count;
  logic [ADDR_W-1:0]   r_wptr;
  logic                r_overflow;
  logic                r_wrapped;
  logic [31:0]         r_words;

  logic                w_start_run;
  logic                w_push;
  logic                w_drop;
  logic                w_write;
  logic                w_pop;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode plus push/drop/write qualifiers; the FIFO count used
  // for the full test is the registered one, so a same-cycle pop never makes
  // room for an arriving sample.
  always_comb begin
    w_state_nxt = r_state;
    w_start_run = 1'b0;
    w_push      = 1'b0;
    w_drop      = 1'b0;
    w_write     = (r_state != S_IDLE) && (r_count != '0);
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_start_run = 1'b1;
        end
      end
      S_RUN: begin
        if (stop) w_state_nxt = S_DRAIN;
        if (sample_valid) begin
          if (r_count < c_depth) w_push = 1'b1;
          else                   w_drop = 1'b1;
        end
      end
      S_DRAIN: begin
        if (r_count == '0) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_pop = w_write && !avm.avm_waitrequest;
  end

  // FIFO storage; contents need no reset because the count gates every read
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= sample_data;
  end

  // FIFO pointers, ring write pointer and status counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_wptr     <= c_base;
      r_overflow <= 1'b0;
      r_wrapped  <= 1'b0;
      r_words    <= '0;
    end else if (w_start_run) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_wptr     <= c_base;
      r_overflow <= 1'b0;
      r_wrapped  <= 1'b0;
      r_words    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
        r_words  <= r_words + 32'd1;
        if (r_wptr == c_last) begin
          r_wptr    <= c_base;
          r_wrapped <= 1'b1;
        end else begin
          r_wptr <= r_wptr + ADDR_W'(1);
        end
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign avm.avm_write     = w_write;
  assign avm.avm_address   = r_wptr;
  assign avm.avm_writedata = w_write ? r_mem[r_rd_ptr] : 16'h0000;

  assign busy          = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign overflow      = r_overflow;
  assign wrapped       = r_wrapped;
  assign words_written = r_words;

endmodule
`default_nettype wire

// File: tb/tb_feed_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_feed_writer
//  Description : Directed-vector bench for feed_writer (BASE_ADDR=16,
//                RING_LEN=4, DEPTH=8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_feed_writer;

  localparam int ADDR_W = 24;
  localparam int BASE   = 16;
  localparam int RING   = 4;
  localparam int DEPTH  = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        sample_valid = 1'b0;
  logic [15:0] sample_data = 16'h0;
  logic        waitreq = 1'b0;
  logic        busy;
  logic        overflow;
  logic        wrapped;
  logic [31:0] words_written;

  int n_pass  = 0;
  int n_total = 0;

  feed_writer_if #(.ADDR_W(ADDR_W)) bus ();
  assign bus.avm_waitrequest = waitreq;

  feed_writer #(
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE),
    .RING_LEN  (RING),
    .DEPTH     (DEPTH)
  ) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .stop          (stop),
    .sample_valid  (sample_valid),
    .sample_data   (sample_data),
    .avm           (bus.master),
    .busy          (busy),
    .overflow      (overflow),
    .wrapped       (wrapped),
    .words_written (words_written)
  );

  always #5 clk = ~clk;

  // Record every accepted write (address, data, wrapped before the accept)
  logic [ADDR_W-1:0] q_addr [$];
  logic [15:0]       q_data [$];
  logic              q_wrap [$];

  always @(negedge clk) begin
    if (rst_n && bus.avm_write && !waitreq) begin
      q_addr.push_back(bus.avm_address);
      q_data.push_back(bus.avm_writedata);
      q_wrap.push_back(wrapped);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic send(input logic [15:0] d);
    sample_valid = 1'b1;
    sample_data  = d;
    cyc();
    sample_valid = 1'b0;
  endtask

  task automatic end_run();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (busy && k < 200) begin
      cyc();
      k++;
    end
    check(name, 64'(busy), 64'd0);
  endtask

  task automatic clear_q();
    q_addr.delete();
    q_data.delete();
    q_wrap.delete();
  endtask

  typedef struct {
    logic        st;
    logic        sp;
    logic        v;
    logic [15:0] d;
    logic        e_write;
    logic [23:0] e_addr;
    logic [15:0] e_data;
    logic        e_busy;
    logic [31:0] e_ww;
  } vec_t;

  vec_t tbl [7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Basic capture: start, 3 samples, stop, no stalls (one row per cycle)
    tbl[0] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 24'd16, 16'h0000, 1'b0, 32'd0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 16'h0001, 1'b0, 24'd16, 16'h0000, 1'b1, 32'd0};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 16'h0002, 1'b1, 24'd16, 16'h0001, 1'b1, 32'd0};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 16'h0003, 1'b1, 24'd17, 16'h0002, 1'b1, 32'd1};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 24'd18, 16'h0003, 1'b1, 32'd2};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 24'd19, 16'h0000, 1'b1, 32'd3};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 24'd19, 16'h0000, 1'b0, 32'd3};

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("reset_overflow", 64'(overflow), 64'd0);
    check("reset_wrapped", 64'(wrapped), 64'd0);

    for (int i = 0; i < 7; i++) begin
      start        = tbl[i].st;
      stop         = tbl[i].sp;
      sample_valid = tbl[i].v;
      sample_data  = tbl[i].d;
      #2;
      check($sformatf("basic[%0d]_write", i), 64'(bus.avm_write), 64'(tbl[i].e_write));
      check($sformatf("basic[%0d]_addr", i), 64'(bus.avm_address), 64'(tbl[i].e_addr));
      check($sformatf("basic[%0d]_data", i), 64'(bus.avm_writedata), 64'(tbl[i].e_data));
      check($sformatf("basic[%0d]_busy", i), 64'(busy), 64'(tbl[i].e_busy));
      check($sformatf("basic[%0d]_words", i), 64'(words_written), 64'(tbl[i].e_ww));
      @(posedge clk);
      #1;
    end
    start = 1'b0; stop = 1'b0; sample_valid = 1'b0;

    // Wrap: 6 samples through a 4-word ring
    clear_q();
    pulse_start();
    for (int k = 0; k < 6; k++) send(16'h0100 + 16'(k));
    end_run();
    wait_idle("wrap_idle");
    check("wrap_count", 64'(q_addr.size()), 64'd6);
    for (int k = 0; k < 6 && k < q_addr.size(); k++) begin
      check($sformatf("wrap_addr[%0d]", k), 64'(q_addr[k]), 64'(BASE + (k % RING)));
      check($sformatf("wrap_data[%0d]", k), 64'(q_data[k]), 64'(16'h0100 + 16'(k)));
      check($sformatf("wrap_flag[%0d]", k), 64'(q_wrap[k]), 64'(k >= 4));
    end
    check("wrap_sticky", 64'(wrapped), 64'd1);
    check("wrap_words", 64'(words_written), 64'd6);
    check("wrap_no_ovf", 64'(overflow), 64'd0);

    // Overflow: slave stalled, 10 samples into an 8-deep FIFO
    clear_q();
    waitreq = 1'b1;
    pulse_start();
    check("ovf_start_clears_wrapped", 64'(wrapped), 64'd0);
    for (int k = 0; k < 10; k++) begin
      send(16'h0200 + 16'(k));
      if (k == 7) check("ovf_not_yet", 64'(overflow), 64'd0);
    end
    check("ovf_set", 64'(overflow), 64'd1);
    check("ovf_head_data", 64'(bus.avm_writedata), 64'h0200);
    check("ovf_head_addr", 64'(bus.avm_address), 64'(BASE));
    end_run();
    waitreq = 1'b0;
    wait_idle("ovf_idle");
    check("ovf_count", 64'(q_data.size()), 64'd8);
    for (int k = 0; k < 8 && k < q_data.size(); k++)
      check($sformatf("ovf_data[%0d]", k), 64'(q_data[k]), 64'(16'h0200 + 16'(k)));
    check("ovf_words", 64'(words_written), 64'd8);

    // Full FIFO with a pop in the same cycle still drops the sample
    clear_q();
    waitreq = 1'b1;
    pulse_start();
    check("popdrop_start_clears_ovf", 64'(overflow), 64'd0);
    for (int k = 0; k < 8; k++) send(16'h0300 + 16'(k));
    waitreq = 1'b0;
    send(16'hDEAD);
    check("popdrop_ovf", 64'(overflow), 64'd1);
    end_run();
    wait_idle("popdrop_idle");
    check("popdrop_count", 64'(q_data.size()), 64'd8);
    if (q_data.size() == 8) check("popdrop_last", 64'(q_data[7]), 64'h0307);

    // Stall stability: first write held for 5 cycles
    clear_q();
    waitreq = 1'b1;
    pulse_start();
    send(16'h5A5A);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall[%0d]_write", i), 64'(bus.avm_write), 64'd1);
      check($sformatf("stall[%0d]_addr", i), 64'(bus.avm_address), 64'(BASE));
      check($sformatf("stall[%0d]_data", i), 64'(bus.avm_writedata), 64'h5A5A);
      check($sformatf("stall[%0d]_words", i), 64'(words_written), 64'd0);
      cyc();
    end
    waitreq = 1'b0;
    cyc();
    check("stall_accepted_words", 64'(words_written), 64'd1);
    check("stall_write_low", 64'(bus.avm_write), 64'd0);
    check("stall_one_write", 64'(q_data.size()), 64'd1);
    end_run();
    wait_idle("stall_idle");

    // Reset in the middle of a stalled write with 4 words queued
    waitreq = 1'b0;
    pulse_start();
    send(16'h0001);
    send(16'h0002);
    cyc();
    waitreq = 1'b1;
    for (int k = 0; k < 4; k++) send(16'h0500 + 16'(k));
    check("rst_pre_words", 64'(words_written), 64'd2);
    check("rst_pre_addr", 64'(bus.avm_address), 64'(BASE + 2));
    rst_n = 1'b0;
    cyc();
    check("rst_write", 64'(bus.avm_write), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_words", 64'(words_written), 64'd0);
    check("rst_addr", 64'(bus.avm_address), 64'(BASE));
    check("rst_data", 64'(bus.avm_writedata), 64'd0);
    rst_n = 1'b1;
    waitreq = 1'b0;
    clear_q();
    pulse_start();
    send(16'h7777);
    end_run();
    wait_idle("rst_resume_idle");
    check("rst_resume_count", 64'(q_data.size()), 64'd1);
    if (q_data.size() == 1) begin
      check("rst_resume_addr", 64'(q_addr[0]), 64'(BASE));
      check("rst_resume_data", 64'(q_data[0]), 64'h7777);
    end

    // Simultaneous start+stop in RUN: DRAIN, flags kept, DRAIN ignores samples
    clear_q();
    waitreq = 1'b0;
    pulse_start();
    send(16'h0001);
    send(16'h0002);
    cyc();
    waitreq = 1'b1;
    for (int k = 0; k < 9; k++) send(16'h0400 + 16'(k));
    start = 1'b1;
    stop  = 1'b1;
    cyc();
    start = 1'b0;
    stop  = 1'b0;
    check("ss_busy", 64'(busy), 64'd1);
    check("ss_ovf_kept", 64'(overflow), 64'd1);
    check("ss_words_kept", 64'(words_written), 64'd2);
    send(16'hBEEF);
    waitreq = 1'b0;
    wait_idle("ss_idle");
    check("ss_words", 64'(words_written), 64'd10);
    check("ss_wrapped", 64'(wrapped), 64'd1);
    check("ss_count", 64'(q_data.size()), 64'd10);
    if (q_data.size() == 10) check("ss_last", 64'(q_data[9]), 64'h0407);

    // IDLE ignores samples and stop
    sample_valid = 1'b1;
    sample_data  = 16'h1111;
    stop         = 1'b1;
    cyc();
    sample_valid = 1'b0;
    stop         = 1'b0;
    cyc();
    check("idle_write", 64'(bus.avm_write), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_words", 64'(words_written), 64'd10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
